// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  // Access sequencer states; one access walks all four in order.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StCapture = 2'd2,
    StResp    = 2'd3
  } arb_state_e;

  // Requester indices, also used as the grant encoding.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int unsigned CONFLICT_CNT_W = 16;

  // Saturating increment for the conflict counter.
  function automatic logic [CONFLICT_CNT_W-1:0] sat_inc(input logic [CONFLICT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of requester A/B handshakes plus the RAM-side port of the arbiter.
// slave: arbiter view. master: requesters + RAM view.
interface ram_port_arbiter_if #(
  parameter int unsigned RAM_ADDR_WIDTH = 8,
  parameter int unsigned RAM_DATA_WIDTH = 8
) ();

  logic                      in_a_req;
  logic                      in_a_wr;
  logic [RAM_ADDR_WIDTH-1:0] in_a_addr;
  logic [RAM_DATA_WIDTH-1:0] in_a_data;
  logic                      out_a_ack;
  logic [RAM_DATA_WIDTH-1:0] out_a_data;

  logic                      in_b_req;
  logic                      in_b_wr;
  logic [RAM_ADDR_WIDTH-1:0] in_b_addr;
  logic [RAM_DATA_WIDTH-1:0] in_b_data;
  logic                      out_b_ack;
  logic [RAM_DATA_WIDTH-1:0] out_b_data;

  logic [RAM_ADDR_WIDTH-1:0] out_ram_addr;
  logic [RAM_DATA_WIDTH-1:0] out_ram_data;
  logic                      out_ram_wr;
  logic [RAM_DATA_WIDTH-1:0] in_ram_data;

  logic                      out_busy;

  modport slave (
    input  in_a_req, in_a_wr, in_a_addr, in_a_data,
    input  in_b_req, in_b_wr, in_b_addr, in_b_data,
    input  in_ram_data,
    output out_a_ack, out_a_data, out_b_ack, out_b_data,
    output out_ram_addr, out_ram_data, out_ram_wr, out_busy
  );

  modport master (
    output in_a_req, in_a_wr, in_a_addr, in_a_data,
    output in_b_req, in_b_wr, in_b_addr, in_b_data,
    output in_ram_data,
    input  out_a_ack, out_a_data, out_b_ack, out_b_data,
    input  out_ram_addr, out_ram_data, out_ram_wr, out_busy
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant: on a tie the requester that was
// not granted last wins; a lone request always wins.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       grant_o
);

  // Pick the winner from the current requests and the previous grant.
  always_comb begin
    valid_o = |req_i;
    grant_o = REQ_A;
    if (req_i[REQ_A] && req_i[REQ_B]) begin
      grant_o = ~last_grant_i;
    end else if (req_i[REQ_B]) begin
      grant_o = REQ_B;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one registered-read, write-through single-port
// RAM between requesters A and B. Each access runs IDLE->ISSUE->CAPTURE->RESP.
// Optional: define RAM_ARB_CONFLICT_CNT_EN to add the saturating
// out_conflict_cnt port counting IDLE edges with both requests high.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned RAM_ADDR_WIDTH = 8,
  parameter int unsigned RAM_DATA_WIDTH = 8
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
`ifdef RAM_ARB_CONFLICT_CNT_EN
  output logic [CONFLICT_CNT_W-1:0] out_conflict_cnt,
`endif
  ram_port_arbiter_if.slave         bus
);

  arb_state_e                state_q;
  logic                      last_grant_q;
  logic                      grant_q;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q;
  logic [RAM_DATA_WIDTH-1:0] ram_data_q;
  logic                      ram_wr_q;
  logic                      a_ack_q;
  logic                      b_ack_q;
  logic [RAM_DATA_WIDTH-1:0] a_data_q;
  logic [RAM_DATA_WIDTH-1:0] b_data_q;

  logic [1:0] req;
  logic       arb_valid;
  logic       arb_grant;

  assign req[REQ_A] = bus.in_a_req;
  assign req[REQ_B] = bus.in_b_req;

  rr_arb2 u_rr_arb2 (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .valid_o      (arb_valid),
    .grant_o      (arb_grant)
  );

  // Access sequencer: registers the winner onto the RAM port, pulses the
  // write for one cycle, captures read data and pulses the winner's ack.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q      <= StIdle;
      last_grant_q <= REQ_B;
      grant_q      <= REQ_A;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_wr_q     <= 1'b0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_data_q     <= '0;
      b_data_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            if (arb_grant == REQ_B) begin
              ram_addr_q <= bus.in_b_addr;
              ram_data_q <= bus.in_b_data;
              ram_wr_q   <= bus.in_b_wr;
            end else begin
              ram_addr_q <= bus.in_a_addr;
              ram_data_q <= bus.in_a_data;
              ram_wr_q   <= bus.in_a_wr;
            end
            // Any grant moves the round-robin pointer, so a tie after a
            // lone access still favours the other side.
            last_grant_q <= arb_grant;
            grant_q      <= arb_grant;
            state_q      <= StIssue;
          end else begin
            ram_wr_q <= 1'b0;
          end
        end
        StIssue: begin
          // RAM samples the port at this edge; drop write so it lasts one cycle.
          ram_wr_q <= 1'b0;
          state_q  <= StCapture;
        end
        StCapture: begin
          // Write-through RAM returns the written value, so writes echo here.
          if (grant_q == REQ_B) begin
            b_data_q <= bus.in_ram_data;
            b_ack_q  <= 1'b1;
          end else begin
            a_data_q <= bus.in_ram_data;
            a_ack_q  <= 1'b1;
          end
          state_q <= StResp;
        end
        StResp: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef RAM_ARB_CONFLICT_CNT_EN
  logic [CONFLICT_CNT_W-1:0] conflict_q;

  // Count IDLE edges where both requesters compete, saturating at all-ones.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      conflict_q <= '0;
    end else if ((state_q == StIdle) && (&req)) begin
      conflict_q <= sat_inc(conflict_q);
    end
  end

  assign out_conflict_cnt = conflict_q;
`endif

  assign bus.out_ram_addr = ram_addr_q;
  assign bus.out_ram_data = ram_data_q;
  assign bus.out_ram_wr   = ram_wr_q;
  assign bus.out_a_ack    = a_ack_q;
  assign bus.out_a_data   = a_data_q;
  assign bus.out_b_ack    = b_ack_q;
  assign bus.out_b_data   = b_data_q;
  assign bus.out_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural write-through RAM,
// a shadow memory for expected data and an ack-ordered scoreboard.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.RAM_ADDR_WIDTH(8), .RAM_DATA_WIDTH(8)) bus ();

`ifdef RAM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  ram_port_arbiter #(
    .RAM_ADDR_WIDTH (8),
    .RAM_DATA_WIDTH (8)
  ) dut (
    .in_clk           (clk),
    .in_rst           (rst),
`ifdef RAM_ARB_CONFLICT_CNT_EN
    .out_conflict_cnt (conflict_cnt),
`endif
    .bus              (bus)
  );

  typedef struct {
    logic       id;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] mem[256];
  logic [7:0] shadow[256];
  logic [7:0] ram_rd_q = 8'h00;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         wr_run = 0;
  int         wr_total = 0;
  int         wr_max = 0;

  // Single-port RAM: registered read, write-through.
  always @(posedge clk) begin
    if (bus.out_ram_wr) begin
      mem[bus.out_ram_addr] <= bus.out_ram_data;
      ram_rd_q <= bus.out_ram_data;
    end else begin
      ram_rd_q <= mem[bus.out_ram_addr];
    end
  end
  assign bus.in_ram_data = ram_rd_q;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: write pulse width and ack ordering/data against the scoreboard.
  always @(negedge clk) begin
    if (bus.out_ram_wr) begin
      wr_run++;
      wr_total++;
      if (wr_run > wr_max) wr_max = wr_run;
    end else begin
      wr_run = 0;
    end
    if (bus.out_a_ack || bus.out_b_ack) begin
      check("ack_exclusive", {31'b0, bus.out_a_ack & bus.out_b_ack}, 32'd0);
      check("sb_has_entry", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("ack_id", {31'b0, bus.out_b_ack}, {31'b0, mon_e.id});
        check("ack_data", bus.out_b_ack ? bus.out_b_data : bus.out_a_data, mon_e.data);
      end
    end
  end

  task automatic drive_req(input logic id, input logic req, input logic wr,
                           input logic [7:0] addr, input logic [7:0] data);
    if (id == REQ_B) begin
      bus.in_b_req = req; bus.in_b_wr = wr; bus.in_b_addr = addr; bus.in_b_data = data;
    end else begin
      bus.in_a_req = req; bus.in_a_wr = wr; bus.in_a_addr = addr; bus.in_a_data = data;
    end
  endtask

  task automatic push_exp(input logic id, input logic wr, input logic [7:0] addr,
                          input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = wr ? data : shadow[addr];
    if (wr) shadow[addr] = data;
    sb.push_back(e);
  endtask

  // Lone access from IDLE; call just after a rising edge.
  task automatic do_access(input logic id, input logic wr, input logic [7:0] addr,
                           input logic [7:0] data, input string tag);
    int c0;
    bit got;
    push_exp(id, wr, addr, data);
    drive_req(id, 1'b1, wr, addr, data);
    c0 = cyc;
    @(posedge clk); #1;
    check({tag, "_ram_addr"}, bus.out_ram_addr, addr);
    check({tag, "_ram_wr"}, {31'b0, bus.out_ram_wr}, {31'b0, wr});
    check({tag, "_busy"}, {31'b0, bus.out_busy}, 32'd1);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id == REQ_B ? bus.out_b_ack : bus.out_a_ack) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_acked"}, {31'b0, got}, 32'd1);
    check({tag, "_latency"}, cyc - c0, 32'd3);
    @(posedge clk); #1;
    drive_req(id, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a_tie[4];
    logic [7:0] b_tie[4];
    int         t_ack[4];
    int         n, na, nb, w0;
    bit         got;

    rst = 1'b1;
    drive_req(REQ_A, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_req(REQ_B, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'hA5;
    end
    mem[8'h10] = 8'h5A;
    mem[8'h40] = 8'h11;
    mem[8'h41] = 8'h22;
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];

    // Reset state.
    #1;
    check("rst_a_ack", {31'b0, bus.out_a_ack}, 32'd0);
    check("rst_b_ack", {31'b0, bus.out_b_ack}, 32'd0);
    check("rst_a_data", bus.out_a_data, 32'd0);
    check("rst_b_data", bus.out_b_data, 32'd0);
    check("rst_ram_addr", bus.out_ram_addr, 32'd0);
    check("rst_ram_data", bus.out_ram_data, 32'd0);
    check("rst_ram_wr", {31'b0, bus.out_ram_wr}, 32'd0);
    check("rst_busy", {31'b0, bus.out_busy}, 32'd0);
`ifdef RAM_ARB_CONFLICT_CNT_EN
    check("rst_conflict", conflict_cnt, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single read by A.
    w0 = wr_total;
    do_access(REQ_A, 1'b0, 8'h10, 8'h00, "t1_read");
    check("t1_no_write", wr_total - w0, 32'd0);
    repeat (2) @(posedge clk);
    #1 check("t1_data_held", bus.out_a_data, 32'h5A);

    // Write then read by B.
    w0 = wr_total;
    do_access(REQ_B, 1'b1, 8'h20, 8'h3C, "t2_write");
    check("t2_one_write_cycle", wr_total - w0, 32'd1);
    do_access(REQ_B, 1'b0, 8'h20, 8'h00, "t2_read");

    // Back-to-back reads by A with req held: acks 4 cycles apart.
    for (int i = 0; i < 4; i++) push_exp(REQ_A, 1'b0, 8'(i), 8'h00);
    drive_req(REQ_A, 1'b1, 1'b0, 8'h00, 8'h00);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_a_ack) begin
        t_ack[n] = cyc;
        n++;
        if (n == 4) break;
        drive_req(REQ_A, 1'b1, 1'b0, 8'(n), 8'h00);
      end
    end
    check("t4_ack_count", n, 32'd4);
    for (int i = 1; i < 4; i++) check("t4_ack_spacing", t_ack[i] - t_ack[i-1], 32'd4);
    @(posedge clk); #1;
    drive_req(REQ_A, 1'b0, 1'b0, 8'h00, 8'h00);

    // Tie from reset release: grants alternate starting with A.
    rst = 1'b1;
    a_tie[0] = 8'h00; a_tie[1] = 8'h01; a_tie[2] = 8'h02; a_tie[3] = 8'h03;
    b_tie[0] = 8'h20; b_tie[1] = 8'h10; b_tie[2] = 8'h30; b_tie[3] = 8'h31;
    for (int i = 0; i < 3; i++) begin
      push_exp(REQ_A, 1'b0, a_tie[i], 8'h00);
      push_exp(REQ_B, 1'b0, b_tie[i], 8'h00);
    end
    drive_req(REQ_A, 1'b1, 1'b0, a_tie[0], 8'h00);
    drive_req(REQ_B, 1'b1, 1'b0, b_tie[0], 8'h00);
    @(posedge clk); #1 rst = 1'b0;
    na = 0; nb = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.out_a_ack) begin
        na++;
        if (na < 4) drive_req(REQ_A, 1'b1, 1'b0, a_tie[na], 8'h00);
      end
      if (bus.out_b_ack) begin
        nb++;
        if (nb < 4) drive_req(REQ_B, 1'b1, 1'b0, b_tie[nb], 8'h00);
      end
      if (na + nb == 6) break;
    end
    check("t3_a_grants", na, 32'd3);
    check("t3_b_grants", nb, 32'd3);
`ifdef RAM_ARB_CONFLICT_CNT_EN
    check("t3_conflict_cnt", conflict_cnt, 32'd6);
`endif
    @(posedge clk); #1;
    drive_req(REQ_A, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_req(REQ_B, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset during ISSUE of an A write: abort, no ack, RAM untouched.
    drive_req(REQ_A, 1'b1, 1'b1, 8'h40, 8'h77);
    @(posedge clk); #1;
    check("t5_issue_wr", {31'b0, bus.out_ram_wr}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_ram_wr", {31'b0, bus.out_ram_wr}, 32'd0);
    check("t5_rst_ram_addr", bus.out_ram_addr, 32'd0);
    check("t5_rst_ram_data", bus.out_ram_data, 32'd0);
    check("t5_rst_busy", {31'b0, bus.out_busy}, 32'd0);
    check("t5_rst_a_data", bus.out_a_data, 32'd0);
    check("t5_rst_b_data", bus.out_b_data, 32'd0);
    drive_req(REQ_A, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    // Tie after reset: A first; A's read proves the aborted write never landed.
    push_exp(REQ_A, 1'b0, 8'h40, 8'h00);
    push_exp(REQ_B, 1'b0, 8'h41, 8'h00);
    drive_req(REQ_A, 1'b1, 1'b0, 8'h40, 8'h00);
    drive_req(REQ_B, 1'b1, 1'b0, 8'h41, 8'h00);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_a_ack || bus.out_b_ack) begin
        got = 1'b1;
        break;
      end
    end
    check("t5_first_ack_seen", {31'b0, got}, 32'd1);
    check("t5_first_is_a", {31'b0, bus.out_a_ack}, 32'd1);
    @(posedge clk); #1;
    drive_req(REQ_A, 1'b0, 1'b0, 8'h00, 8'h00);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_b_ack) begin
        got = 1'b1;
        break;
      end
    end
    check("t5_b_acked", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    drive_req(REQ_B, 1'b0, 1'b0, 8'h00, 8'h00);
`ifdef RAM_ARB_CONFLICT_CNT_EN
    check("t5_conflict_cnt", conflict_cnt, 32'd1);

    // Saturation: preset near the top, then three more conflicts.
    force dut.conflict_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.conflict_q;
    check("t6_preset", conflict_cnt, 32'hFFFE);
    push_exp(REQ_A, 1'b0, 8'h50, 8'h00);
    push_exp(REQ_B, 1'b0, 8'h60, 8'h00);
    push_exp(REQ_A, 1'b0, 8'h51, 8'h00);
    drive_req(REQ_A, 1'b1, 1'b0, 8'h50, 8'h00);
    drive_req(REQ_B, 1'b1, 1'b0, 8'h60, 8'h00);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_a_ack || bus.out_b_ack) begin
        n++;
        if (n == 3) break;
        if (bus.out_a_ack) drive_req(REQ_A, 1'b1, 1'b0, 8'h51, 8'h00);
      end
    end
    check("t6_acks", n, 32'd3);
    check("t6_saturated", conflict_cnt, 32'hFFFF);
    @(posedge clk); #1;
    drive_req(REQ_A, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_req(REQ_B, 1'b0, 1'b0, 8'h00, 8'h00);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("wr_pulse_max", wr_max, 32'd1);
    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
